// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer: opcode values understood
// by the 4-bit ALU, sequencer FSM state encoding, the packed command layout
// stored in the command FIFO, and a divide-by-zero helper.
// ----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int CMD_W = 12;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_ROL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_NAND = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_GT   = 4'd14;
    localparam logic [3:0] OP_EQ   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // FIFO word layout: {sel, b, a}
    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] b;
        logic [3:0] a;
    } cmd_t;

    // A divide with a zero divisor is answered locally instead of trusting the ALU.
    function automatic logic is_divzero(input logic [3:0] sel, input logic [3:0] b);
        return (sel == OP_DIV) && (b == 4'd0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// ----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous FIFO holding pending ALU commands. No fall-through: a word
// written into an empty FIFO becomes visible at o_dout the following cycle.
// Read data is presented combinationally from the head entry so the consumer
// can pop and use the word on the same edge.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   i_push, i_din   write strobe / data (ignored while full)
//   i_pop           read strobe (ignored while empty)
//   o_dout          head-of-queue word
//   o_full, o_empty status, derived from the pointers
// ----------------------------------------------------------------------------
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CMD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    // One extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_push;
    logic         w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
// Command-side driver for a 4-bit combinational ALU. Commands {a,b,sel} are
// queued in a FIFO, driven one at a time onto the ALU inputs, held for
// SETTLE_CYCLES, and the captured result is returned on a valid/ready port.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (cmd_ready = FIFO not full)
//   cmd_a, cmd_b, cmd_sel        command operands and opcode
//   alu_a, alu_b, alu_sel        registered drive to the ALU
//   alu_result, alu_carry        ALU outputs
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_carry        captured result
//   rsp_sel, rsp_divzero         opcode of the response, divide-by-zero flag
//   busy                         FSM active or commands pending
//   op_count                     completed response handshakes (wraps)
// ----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [3:0] cmd_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_carry,
    output logic [3:0] rsp_sel,
    output logic       rsp_divzero,
    output logic       busy,
    output logic [7:0] op_count
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [3:0]       r_alu_sel;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_result;
    logic             r_rsp_carry;
    logic [3:0]       r_rsp_sel;
    logic             r_rsp_divzero;
    logic [7:0]       r_op_count;

    cmd_t             w_push_cmd;
    cmd_t             w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;

    assign w_push_cmd = '{sel: cmd_sel, b: cmd_b, a: cmd_a};
    // The FSM only takes a new command while idle; pop and load share one edge.
    assign w_pop      = (r_state == ST_IDLE) && !w_fifo_empty;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_din   (w_push_cmd),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_sel     <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_carry   <= 1'b0;
            r_rsp_sel     <= '0;
            r_rsp_divzero <= 1'b0;
            r_op_count    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_alu_a   <= w_head.a;
                        r_alu_b   <= w_head.b;
                        r_alu_sel <= w_head.sel;
                        r_cnt     <= CNT_W'(SETTLE_CYCLES - 1);
                        r_state   <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == '0) begin
                        if (is_divzero(r_alu_sel, r_alu_b)) begin
                            r_rsp_result  <= 8'hFF;
                            r_rsp_carry   <= 1'b0;
                            r_rsp_divzero <= 1'b1;
                        end else begin
                            r_rsp_result  <= alu_result;
                            r_rsp_carry   <= alu_carry;
                            r_rsp_divzero <= 1'b0;
                        end
                        r_rsp_sel   <= r_alu_sel;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    // rsp_valid is always high here, so ready alone completes the handshake.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + 8'd1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = !w_fifo_full;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_sel     = r_alu_sel;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_carry   = r_rsp_carry;
    assign rsp_sel     = r_rsp_sel;
    assign rsp_divzero = r_rsp_divzero;
    assign op_count    = r_op_count;
    assign busy        = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
